// File: rtl/lbm_divider.sv
// -----------------------------------------------------------------------------
// lbm_divider
//
// Iterative signed fixed-point divider for the LBM macroscopic-variable stage.
// It computes quotient = trunc((dividend * 2^FRAC_BITS) / divisor), with the
// result rounded toward zero and saturated to the signed DATA_WIDTH range.
// The core is a restoring shift-subtract loop over the operand magnitudes,
// followed by a single sign/saturation fix-up cycle.
//
// Handshake: div_start is a request strobe that is only honoured when the
// block is idle (div_busy = 0 at the sampling edge). div_start while busy is
// dropped, not queued. Operands are captured on the accepting edge. div_valid
// is a one-cycle pulse marking a new quotient/div_by_zero pair. That pair is
// then held until the next result. There is no back-pressure.
//
// Ports:
//   Clk          in   rising-edge clock
//   Reset        in   synchronous active-low reset
//   div_start    in   request strobe (sampled in IDLE only)
//   dividend     in   signed numerator, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//   divisor      in   signed denominator, same format
//   quotient     out  signed result, held until the next result
//   div_valid    out  one-cycle result strobe
//   div_busy     out  high whenever the FSM is not IDLE
//   div_by_zero  out  qualifies the held quotient
// -----------------------------------------------------------------------------
module lbm_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic                  div_valid,
    output logic                  div_busy,
    output logic                  div_by_zero
);

    localparam int DW = DATA_WIDTH;
    localparam int N  = DATA_WIDTH + FRAC_BITS;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DW_ONE   = {{(DW-1){1'b0}}, 1'b1};

    // Saturation limits, expressed against the N-bit quotient magnitude.
    localparam logic [N-1:0]  MAX_POS_MAG = {{(N-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [N-1:0]  MAX_NEG_MAG = {{(N-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SAT_POS     = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_NEG     = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW:0]   rem_q, rem_d;        // partial remainder, DW+1 bits
    logic [N-1:0]  num_q, num_d;        // numerator magnitude, shifted out MSB first
    logic [N-1:0]  qmag_q, qmag_d;      // quotient magnitude, shifted in LSB first
    logic [DW-1:0] dmag_q, dmag_d;      // divisor magnitude
    logic          sign_q, sign_d;      // result sign
    logic          dbz_pend_q, dbz_pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          dbz_q, dbz_d;

    logic [DW-1:0] dividend_mag;
    logic [DW-1:0] divisor_mag;
    logic [DW+1:0] rem_shift;
    logic          rem_ge;
    logic [DW-1:0] fix_result;

    // Two's-complement magnitude; the most negative value maps to 2^(DW-1),
    // which is still representable as an unsigned DW-bit number.
    always_comb begin
        dividend_mag = dividend[DW-1] ? (~dividend + DW_ONE) : dividend;
        divisor_mag  = divisor[DW-1]  ? (~divisor  + DW_ONE) : divisor;
    end

    // One restoring step. The remainder is always below |divisor| <= 2^(DW-1)
    // before the shift, so the shifted value cannot overflow DW+1 bits; the
    // extra top bit only keeps the compare free of truncation.
    always_comb begin
        rem_shift = {rem_q, num_q[N-1]};
        rem_ge    = (rem_shift >= {2'b00, dmag_q});
    end

    // Sign application and saturation. For divide-by-zero the numerator
    // register still holds the dividend magnitude, and the captured sign equals
    // the dividend sign because a zero divisor is non-negative.
    always_comb begin
        fix_result = '0;
        if (dbz_pend_q) begin
            if (num_q == '0) begin
                fix_result = '0;
            end else if (sign_q) begin
                fix_result = SAT_NEG;
            end else begin
                fix_result = SAT_POS;
            end
        end else if (sign_q) begin
            if (qmag_q >= MAX_NEG_MAG) begin
                fix_result = SAT_NEG;
            end else begin
                fix_result = ~qmag_q[DW-1:0] + DW_ONE;
            end
        end else begin
            if (qmag_q > MAX_POS_MAG) begin
                fix_result = SAT_POS;
            end else begin
                fix_result = qmag_q[DW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        num_d      = num_q;
        qmag_d     = qmag_q;
        dmag_d     = dmag_q;
        sign_d     = sign_q;
        dbz_pend_d = dbz_pend_q;
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
        dbz_d      = dbz_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (div_start) begin
                    num_d      = {dividend_mag, {FRAC_BITS{1'b0}}};
                    dmag_d     = divisor_mag;
                    sign_d     = dividend[DW-1] ^ divisor[DW-1];
                    rem_d      = '0;
                    qmag_d     = '0;
                    cnt_d      = '0;
                    dbz_pend_d = (divisor == '0);
                    busy_d     = 1'b1;
                    state_d    = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d  = (DW+1)'(rem_ge ? (rem_shift - {2'b00, dmag_q}) : rem_shift);
                qmag_d = {qmag_q[N-2:0], rem_ge};
                num_d  = {num_q[N-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d = fix_result;
                dbz_d      = dbz_pend_q;
                valid_d    = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            num_q      <= '0;
            qmag_q     <= '0;
            dmag_q     <= '0;
            sign_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            cnt_q      <= '0;
            quotient_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            num_q      <= num_d;
            qmag_q     <= qmag_d;
            dmag_q     <= dmag_d;
            sign_q     <= sign_d;
            dbz_pend_q <= dbz_pend_d;
            cnt_q      <= cnt_d;
            quotient_q <= quotient_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            dbz_q      <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign div_valid   = valid_q;
    assign div_busy    = busy_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/lbm_divider.md
# lbm_divider

Iterative signed fixed-point divider serving the LBM macroscopic-variable stage. The controller raises `div_start`, and this block responds with `div_valid` after a fixed latency. The block computes the velocity components ux = (ρ·ux)/ρ and uy = (ρ·uy)/ρ in Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS format. It produces one quotient per request using a restoring shift-subtract datapath, and its result feeds the LD_EN_UX / LD_EN_UY registers.

## Interface
- `DATA_WIDTH`, 32, operand and quotient width, two's complement.
- `FRAC_BITS`, 16, fractional bits of the operand and quotient format.

- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `div_start`  in  1  request strobe; sampled only in IDLE.
- `dividend`  in  DATA_WIDTH  signed numerator (ρ·u); sampled with `div_start`.
- `divisor`  in  DATA_WIDTH  signed denominator (ρ); sampled with `div_start`.
- `quotient`  out  DATA_WIDTH  signed result; held until the next result.
- `div_valid`  out  1  one-cycle pulse, result ready.
- `div_busy`  out  1  high whenever the state is not IDLE.
- `div_by_zero`  out  1  qualifies the current result; held with `quotient`.

## Operation
- Let N = DATA_WIDTH + FRAC_BITS (48 at defaults). The exact result is trunc((dividend·2^FRAC_BITS)/divisor), rounded toward zero.
- States are IDLE, CALC, FIX and DONE.
- IDLE:
  - On `div_start`=1, register the operand magnitudes (|0x80000000| = 2^31, unsigned) and the result sign (sign(dividend) XOR sign(divisor)).
  - Clear the remainder and the bit counter.
  - Go to CALC, or go directly to FIX if divisor = 0.
- CALC:
  - Each cycle, shift the next numerator bit (the dividend magnitude concatenated with FRAC_BITS zeros, MSB first) into the remainder.
  - If remainder ≥ |divisor|, subtract |divisor| and shift a 1 into the quotient magnitude; otherwise shift in a 0.
  - The remainder is DATA_WIDTH+1 bits wide; the quotient magnitude is N bits wide.
  - After exactly N iterations, go to FIX.
- FIX:
  - Saturate to the range: the maximum positive is 2^(DATA_WIDTH−1)−1 and the most negative is −2^(DATA_WIDTH−1).
  - Apply the sign.
  - Register `quotient` and `div_by_zero`.
  - Go to DONE.
- Divide by zero:
  - The result is 0x7FFFFFFF if dividend > 0, 0x80000000 if dividend < 0, and 0 if dividend = 0.
  - `div_by_zero`=1 in all three cases.
- DONE: assert `div_valid` for one cycle, then return to IDLE.
- `div_start` in any state other than IDLE is ignored; the in-flight operation is unaffected and no request is queued.
- Operand inputs are don't-care outside the cycle in which `div_start` is sampled.

## Timing
- Reset (`Reset`=0 at a rising edge):
  - State goes to IDLE.
  - `quotient`=0, `div_valid`=0, `div_busy`=0, `div_by_zero`=0.
  - Remainder and counter are cleared.
- Reset mid-operation aborts the operation; no `div_valid` is produced.
- Define k as the edge at which `div_start` is sampled in IDLE.
  - Normal division: `div_busy`=1 from edge k. `quotient` and `div_by_zero` update at edge k+N+1. `div_valid`=1 for the cycle following edge k+N+1, which is 50 cycles after k at defaults. The state returns to IDLE at edge k+N+2.
  - Divide by zero: `quotient` updates at edge k+1, `div_valid` pulses in the cycle after edge k+1, and the state is IDLE at edge k+2.
- `div_busy` falls in the same cycle the state re-enters IDLE. A new `div_start` is accepted at the first edge with `div_busy`=0.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- 0x00010000 / 0x00010000 (1.0/1.0), start sampled at edge k:
  - `quotient`=0x00010000 and `div_by_zero`=0.
  - `div_valid` is high for exactly one cycle, after edge k+49, and `div_busy` is low after edge k+50.
- Signed and truncation cases:
  - 0x00030000 / 0xFFFE0000 (3.0/−2.0) gives 0xFFFE8000.
  - 0x00010000 / 0x00030000 gives 0x00005555.
  - 0xFFFF0000 / 0x00030000 gives 0xFFFFAAAB (truncated toward zero).
- Divide by zero:
  - 0x00050000 / 0 gives 0x7FFFFFFF with `div_by_zero`=1, and `div_valid` after edge k+1.
  - 0xFFFB0000 / 0 gives 0x80000000.
  - 0 / 0 gives 0.
  - The next normal division clears `div_by_zero`.
- Overflow:
  - 0x7FFFFFFF / 0x00000001 saturates to 0x7FFFFFFF.
  - 0x80000000 / 0x00000001 saturates to 0x80000000.
  - `div_by_zero`=0 in both cases.
- Ignored and back-to-back requests:
  - Pulse `div_start` with different operands at k+10 and again at k+N+1 (the DONE cycle): the first result is unchanged and exactly one `div_valid` is produced.
  - A start at k+N+2 is accepted and produces its own correct result.
- Reset mid-operation:
  - Drive `Reset`=0 at edge k+20: at the next edge all outputs are 0, and no `div_valid` appears in the following 60 cycles.
  - A subsequent request completes normally.
